// File: rtl/usr_pkg.sv
// Shared mode encodings for the universal shift register family.
package usr_pkg;
  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;
endpackage

// File: rtl/univ_shift_reg_next.sv
// Combinational next-state for the universal register; shared with the LFSR wrapper.
module univ_shift_reg_next
  import usr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  mode_e            mode,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             sil,
  input  logic             sir,
  output logic [WIDTH-1:0] next_q
);
  always_comb begin
    next_q = q;
    case (mode)
      MODE_HOLD: next_q = q;
      MODE_LOAD: next_q = d;
      MODE_SHL:  next_q = {q[WIDTH-2:0], sil};
      MODE_SHR:  next_q = {sir, q[WIDTH-1:1]};
      MODE_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  next_q = {q[0], q[WIDTH-1:1]};
      MODE_ASR:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_CLR:  next_q = RST_VAL;
      default:   next_q = q;
    endcase
  end
endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: load, shifts, rotates and ASR with true/complement outputs and zero flag.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sil,
  input  logic              sir,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qb,
  output logic              so_msb,
  output logic              so_lsb,
  output logic              zero
);
  generate
    if (WIDTH < 2) begin : g_width_chk
      $error("univ_shift_reg: WIDTH must be >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] next_q;

  univ_shift_reg_next #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_next (
    .mode   (mode_e'(mode)),
    .q      (q),
    .d      (d),
    .sil    (sil),
    .sir    (sir),
    .next_q (next_q)
  );

  // q, qb and zero all come from the same next value so they can never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= RST_VAL;
      qb   <= ~RST_VAL;
      zero <= (RST_VAL == '0);
    end else if (en) begin
      q    <= next_q;
      qb   <= ~next_q;
      zero <= (next_q == '0);
    end
  end

  assign so_msb = q[WIDTH-1];
  assign so_lsb = q[0];

  always_ff @(posedge clk) begin
    if (!rst && en)
      assert (!$isunknown(mode)) else $error("univ_shift_reg: X on mode while enabled");
  end
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: default reset value and a 3C reset-value variant.
module tb_univ_shift_reg;
  logic       clk = 1'b0;
  logic       rst, en, sil, sir;
  logic [2:0] mode;
  logic [7:0] d;
  logic [7:0] qa, qba, qb_, qbb;
  logic       msba, lsba, zeroa, msbb, lsbb, zerob;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sil(sil), .sir(sir),
    .q(qa), .qb(qba), .so_msb(msba), .so_lsb(lsba), .zero(zeroa)
  );

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h3C)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sil(sil), .sir(sir),
    .q(qb_), .qb(qbb), .so_msb(msbb), .so_lsb(lsbb), .zero(zerob)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Complement tracking on every edge once reset has been applied.
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst) rst_seen = 1'b1;
    if (rst_seen) begin
      chk("qb_a_eq_not_q", qba, ~qa);
      chk("qb_b_eq_not_q", qbb, ~qb_);
    end
  end

  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [7:0] dv, input logic sl, input logic sr);
    @(negedge clk);
    rst = r; en = e; mode = m; d = dv; sil = sl; sir = sr;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00; sil = 1'b0; sir = 1'b0;

    // Reset and first load
    step(1, 0, 3'b000, 8'h00, 0, 0);
    step(1, 0, 3'b000, 8'h00, 0, 0);
    chk("rst_q", qa, 8'h00);
    chk("rst_qb", qba, 8'hFF);
    chk("rst_zero", {7'd0, zeroa}, 8'h01);
    chk("rstb_q", qb_, 8'h3C);
    chk("rstb_qb", qbb, 8'hC3);
    chk("rstb_zero", {7'd0, zerob}, 8'h00);
    step(0, 1, 3'b001, 8'hA5, 0, 0);
    chk("load_q", qa, 8'hA5);
    chk("load_qb", qba, 8'h5A);
    chk("load_zero", {7'd0, zeroa}, 8'h00);

    // SHL sil=1 x3, so_msb checked before each edge
    chk("shl0_so_msb", {7'd0, msba}, 8'h01);
    step(0, 1, 3'b010, 8'h00, 1, 0);
    chk("shl1_q", qa, 8'h4B);
    chk("shl1_so_msb", {7'd0, msba}, 8'h00);
    step(0, 1, 3'b010, 8'h00, 1, 0);
    chk("shl2_q", qa, 8'h97);
    chk("shl2_so_msb", {7'd0, msba}, 8'h01);
    step(0, 1, 3'b010, 8'h00, 1, 0);
    chk("shl3_q", qa, 8'h2F);
    chk("shr0_so_lsb", {7'd0, lsba}, 8'h01);
    step(0, 1, 3'b011, 8'h00, 1, 0);
    chk("shr1_q", qa, 8'h17);
    step(0, 1, 3'b011, 8'h00, 1, 0);
    chk("shr2_q", qa, 8'h0B);
    step(0, 1, 3'b011, 8'h00, 0, 1);
    chk("shr_sir1_q", qa, 8'h85);
    step(0, 1, 3'b000, 8'hFF, 1, 1);
    chk("hold_q", qa, 8'h85);

    // Rotates
    step(0, 1, 3'b001, 8'h81, 0, 0);
    step(0, 1, 3'b100, 8'h00, 0, 0);
    chk("rol1_q", qa, 8'h03);
    for (int i = 0; i < 7; i++) step(0, 1, 3'b100, 8'h00, i[0], ~i[0]);
    chk("rol8_q", qa, 8'h81);
    step(0, 1, 3'b101, 8'h00, 0, 0);
    chk("ror1_q", qa, 8'hC0);

    // Arithmetic shift right
    step(0, 1, 3'b001, 8'h90, 0, 0);
    step(0, 1, 3'b110, 8'h00, 0, 0);
    chk("asr1_q", qa, 8'hC8);
    step(0, 1, 3'b110, 8'h00, 0, 0);
    chk("asr2_q", qa, 8'hE4);
    step(0, 1, 3'b001, 8'h70, 0, 0);
    step(0, 1, 3'b110, 8'h00, 1, 1);
    chk("asr_pos_q", qa, 8'h38);

    // Enable low holds; reset beats an enabled load
    step(0, 1, 3'b001, 8'hA5, 0, 0);
    for (int i = 0; i < 4; i++)
      step(0, 0, i[0] ? 3'b010 : 3'b001, 8'h00, i[0], ~i[0]);
    chk("en0_q", qa, 8'hA5);
    chk("en0_zero", {7'd0, zeroa}, 8'h00);
    step(1, 1, 3'b001, 8'hFF, 0, 0);
    chk("rst_wins_q", qa, 8'h00);
    chk("rst_wins_zero", {7'd0, zeroa}, 8'h01);

    // Non-zero reset value variant
    chk("b_rst_q", qb_, 8'h3C);
    chk("b_rst_qb", qbb, 8'hC3);
    step(0, 1, 3'b001, 8'h00, 0, 0);
    chk("b_load0_zero", {7'd0, zerob}, 8'h01);
    step(0, 1, 3'b111, 8'hFF, 1, 1);
    chk("b_clr_q", qb_, 8'h3C);
    chk("b_clr_zero", {7'd0, zerob}, 8'h00);
    chk("a_clr_q", qa, 8'h00);

    step(0, 0, 3'b000, 8'h00, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
